// File: rtl/key_event_ctrl_pkg.sv
// Shared constants for the key event controller: register map, CTRL bit
// positions and the idle (released) key level.
package key_event_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam int EDGE_SEL = 0;

  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_event_ctrl_debounce.sv
// Single-key conditioner: 2-FF synchroniser, debounce counter and stable level,
// with one-cycle press/release pulses that coincide with the stable update.
module key_debounce
  import key_event_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_i,
  output logic stable_o,
  output logic press_o,
  output logic release_o
);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= {2{KEY_RELEASED}};
      cnt_q    <= '0;
      stable_q <= KEY_RELEASED;
    end else begin
      sync_q   <= {sync_q[0], key_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // A return to the stable level before terminal count restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    press_o   = 1'b0;
    release_o = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_d     = '0;
      stable_d  = sync_q[1];
      press_o   = ~sync_q[1];
      release_o = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key controller: per-key debounce, sticky edge capture with W1C,
// interrupt mask and a registered read mux.
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, press, rel;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             ctrl_q, ctrl_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             wr_en;
  logic             unused_wd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_i    (in_port[i]),
      .stable_o (stable[i]),
      .press_o  (press[i]),
      .release_o(rel[i])
    );
  end

  assign wr_en     = chipselect && !write_n;
  assign unused_wd = ^writedata;

  // The event OR comes after the W1C so a same-cycle set wins.
  always_comb begin
    edge_d = edge_q;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (address)
        ADDR_MASK: mask_d = writedata[WIDTH-1:0];
        ADDR_EDGE: edge_d = edge_q & ~writedata[WIDTH-1:0];
        ADDR_CTRL: ctrl_d = writedata[EDGE_SEL];
        default:   ;
      endcase
    end
    edge_d = edge_d | (ctrl_q ? rel : press);
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_CTRL: readdata_d[EDGE_SEL]  = ctrl_q;
      default:   readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q     <= '0;
      mask_q     <= '0;
      ctrl_q     <= 1'b0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edge_q & mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
